alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: operation request present.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-005 SHALL have port aluop, input, 4 bits: operation code from ALU control decode.
REQ-006 SHALL have port a, input, 32 bits: operand A (rs).
REQ-007 SHALL have port b, input, 32 bits: operand B (rt or sign-extended immediate).
REQ-008 SHALL have port shamt, input, 5 bits: shift amount for SLL.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-011 SHALL have port result, output, 32 bits: operation result.
REQ-012 SHALL have port zero, output, 1 bit: high when result equals 0.
REQ-013 SHALL have port illegal, output, 1 bit: high when the completed aluop is unsupported.

Function
REQ-014 SHALL decode aluop as: 4'd0 NOP (result 0), 4'd2 ADD (a+b), 4'd3 SLL (b shifted left by shamt); every other code SHALL be illegal.
REQ-015 SHALL compute ADD modulo 2^32 with carry discarded and no overflow trap.
REQ-016 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-017 SHALL drive in_ready high only in IDLE; in_ready SHALL be combinational from state only.
REQ-018 SHALL accept a request only on a cycle where in_valid and in_ready are both high, capturing aluop, a, b and shamt at that edge.
REQ-019 SHALL ignore aluop, a, b, shamt and in_valid while not in IDLE.
REQ-020 On accepting NOP, ADD or an illegal op, SHALL go IDLE->DONE, with out_valid high on the cycle after acceptance (latency 1).
REQ-021 On accepting SLL with shamt=0, SHALL go IDLE->DONE with result=b (latency 1).
REQ-022 On accepting SLL with shamt=N>0, SHALL load b into a shift register and N into a 5-bit down-counter, enter SHIFT, shift left by one bit and decrement once per cycle, and enter DONE when the counter reaches 0; out_valid SHALL rise N+1 cycles after acceptance.
REQ-023 SLL SHALL fill vacated LSBs with zeros; bits shifted past bit 31 SHALL be discarded.
REQ-024 SHALL drive out_valid high only in DONE.
REQ-025 SHALL hold result, zero and illegal stable while out_valid is high and out_ready is low.
REQ-026 SHALL return DONE->IDLE on the cycle where out_valid and out_ready are both high; in_ready SHALL rise on the following cycle, so there is no same-cycle accept/complete bypass.
REQ-027 SHALL set illegal=1 and result=0 for an unsupported aluop; illegal SHALL be 0 for every supported op.
REQ-028 SHALL derive zero from the registered result, including for NOP and illegal ops, where zero=1.

Reset
REQ-029 On rst_n low, SHALL immediately force state=IDLE, result=0, shift register=0, counter=0 and illegal=0, regardless of clk.
REQ-030 During reset SHALL drive out_valid=0, in_ready=1 and zero=1.
REQ-031 Reset asserted mid-SHIFT or mid-DONE SHALL abandon the operation, with no result produced after deassertion.

Structure
REQ-032 SHALL take aluop code constants (ALUOP_NOP=4'd0, ALUOP_ADD=4'd2, ALUOP_SLL=4'd3) and the FSM state enum from shared package alu_pkg, which the ALU control decoder also uses.
REQ-033 SHALL place the iterative shift register and down-counter in one sub-module, alu_shift_iter, with load/start, busy and result ports; all other logic SHALL be in alu_exec.

Verification
REQ-034 Test ADD: a=32'h0000_0005, b=32'h0000_0007, aluop=2 -> out_valid 1 cycle after accept, result=32'h0000_000C, zero=0, illegal=0.
REQ-035 Test ADD wrap: a=32'hFFFF_FFFF, b=32'h1 -> result=0, zero=1, illegal=0.
REQ-036 Test SLL: b=32'h8000_0001, shamt=4 -> out_valid exactly 5 cycles after accept, result=32'h0000_0010; shamt=0 -> result=b after 1 cycle.
REQ-037 Test backpressure: hold out_ready=0 for 10 cycles after out_valid -> result and flags stable and in_ready=0 throughout; in_ready=1 on the cycle after the handshake.
REQ-038 Test illegal op and reset: aluop=4'd7 -> result=0, illegal=1, zero=1; separately, assert rst_n low at shamt=31 mid-shift -> state IDLE, out_valid=0, no late result.

Source files
------------

// File: rtl/alu_pkg.sv
// Package shared by the ALU control decoder and the ALU execute block.
// Holds the aluop code constants and the execute-stage FSM state type.
package alu_pkg;

    localparam int unsigned ALU_W   = 32;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [3:0] ALUOP_NOP = 4'd0;
    localparam logic [3:0] ALUOP_ADD = 4'd2;
    localparam logic [3:0] ALUOP_SLL = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative left shifter: one bit position per clock.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture din/amt (start a new shift)
//   din, amt   : value to shift and number of positions
//   busy       : positions still outstanding (count != 0)
//   last       : the coming edge performs the final shift
//   result     : current shift register contents
module alu_shift_iter
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [ALU_W-1:0]   din,
    input  logic [SHAMT_W-1:0] amt,
    output logic               busy,
    output logic               last,
    output logic [ALU_W-1:0]   result
);

    logic [ALU_W-1:0]   shift_r;
    logic [SHAMT_W-1:0] cnt_r;

    // Shift register and down-counter: load, then shift/decrement until zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {ALU_W{1'b0}};
            cnt_r   <= {SHAMT_W{1'b0}};
        end else if (load) begin
            shift_r <= din;
            cnt_r   <= amt;
        end else if (cnt_r != {SHAMT_W{1'b0}}) begin
            // Zero fill at the LSB; bit 31 falls off the top.
            shift_r <= {shift_r[ALU_W-2:0], 1'b0};
            cnt_r   <= cnt_r - 5'd1;
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

    assign busy   = (cnt_r != {SHAMT_W{1'b0}});
    assign last   = (cnt_r == 5'd1);
    assign result = shift_r;

endmodule

// File: rtl/alu_exec.sv
// ALU execute block with valid/ready handshakes on both sides.
// Supports NOP, ADD and SLL (iterative, one bit per cycle); every other
// aluop completes as illegal with result 0.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (in_ready only in IDLE)
//   aluop, a, b, shamt  : operation and operands, captured on accept
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   result, zero        : operation result and result==0 flag
//   illegal             : completed aluop was unsupported
module alu_exec
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         aluop,
    input  logic [ALU_W-1:0]   a,
    input  logic [ALU_W-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALU_W-1:0]   result,
    output logic               zero,
    output logic               illegal
);

    alu_state_e         state_r;
    alu_state_e         state_s;
    logic [ALU_W-1:0]   result_r;
    logic [ALU_W-1:0]   result_s;
    logic               illegal_r;
    logic               illegal_s;
    // When set, the result lives in the shifter rather than result_r.
    logic               sel_shift_r;
    logic               sel_shift_s;
    logic               shift_load_s;
    logic               shift_busy_s;
    logic               shift_last_s;
    logic [ALU_W-1:0]   shift_q_s;

    alu_shift_iter u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (shift_load_s),
        .din    (b),
        .amt    (shamt),
        .busy   (shift_busy_s),
        .last   (shift_last_s),
        .result (shift_q_s)
    );

    // Next-state and result-register decode; inputs only matter in IDLE.
    always_comb begin
        state_s      = state_r;
        result_s     = result_r;
        illegal_s    = illegal_r;
        sel_shift_s  = sel_shift_r;
        shift_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    case (aluop)
                        ALUOP_NOP: begin
                            result_s    = {ALU_W{1'b0}};
                            illegal_s   = 1'b0;
                            sel_shift_s = 1'b0;
                            state_s     = ST_DONE;
                        end
                        ALUOP_ADD: begin
                            // Carry out is dropped; no overflow trap.
                            result_s    = a + b;
                            illegal_s   = 1'b0;
                            sel_shift_s = 1'b0;
                            state_s     = ST_DONE;
                        end
                        ALUOP_SLL: begin
                            illegal_s = 1'b0;
                            if (shamt == 5'd0) begin
                                result_s    = b;
                                sel_shift_s = 1'b0;
                                state_s     = ST_DONE;
                            end else begin
                                result_s     = {ALU_W{1'b0}};
                                sel_shift_s  = 1'b1;
                                shift_load_s = 1'b1;
                                state_s      = ST_SHIFT;
                            end
                        end
                        default: begin
                            result_s    = {ALU_W{1'b0}};
                            illegal_s   = 1'b1;
                            sel_shift_s = 1'b0;
                            state_s     = ST_DONE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Move to DONE on the edge that performs the final shift;
                // an idle shifter here is unexpected, so finish rather than hang.
                if (shift_last_s || !shift_busy_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            result_r    <= {ALU_W{1'b0}};
            illegal_r   <= 1'b0;
            sel_shift_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            result_r    <= result_s;
            illegal_r   <= illegal_s;
            sel_shift_r <= sel_shift_s;
        end
    end

    // Both sources are registers and the shifter is idle in DONE, so the
    // output holds steady under backpressure.
    assign result    = sel_shift_r ? shift_q_s : result_r;
    assign zero      = (result == {ALU_W{1'b0}});
    assign illegal   = illegal_r;
    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases with literal expectations
// followed by randomized traffic checked against a transaction-level model.
module tb_alu_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int vectors;
    int miscompares;

    // Model: 0 = idle, 1 = working, 2 = result presented
    int          m_phase;
    int          m_rem;
    logic [31:0] m_res;
    logic        m_ill;

    alu_exec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] x,
                                               input logic [31:0] y, input logic [4:0] s);
        case (op)
            4'd0:    return 32'd0;
            4'd2:    return x + y;
            4'd3:    return y << s;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs presented.
    task automatic model_update();
        if (!rst_n) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_res = ref_result(aluop, a, b, shamt);
                m_ill = !(aluop == 4'd0 || aluop == 4'd2 || aluop == 4'd3);
                if (aluop == 4'd3 && shamt != 5'd0) begin
                    m_rem   = int'(shamt);
                    m_phase = 1;
                end else begin
                    m_phase = 2;
                end
            end
        end else if (m_phase == 1) begin
            m_rem--;
            if (m_rem == 0) m_phase = 2;
        end else begin
            if (out_ready) m_phase = 0;
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
        if (m_phase == 2) begin
            chk("result", result, m_res);
            chk("zero", {31'd0, zero}, {31'd0, m_res == 32'd0});
            chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    // Directed operation with literal expectations; hold = cycles of backpressure.
    task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] s, input logic [31:0] exp_res, input logic exp_ill,
                         input int exp_lat, input int hold);
        int lat;
        in_valid = 1'b1; aluop = op; a = x; b = y; shamt = s; out_ready = 1'b0;
        step();
        in_valid = 1'b1; aluop = 4'd2; a = $urandom; b = $urandom; shamt = 5'd1;
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, exp_lat);
        chk("d_result", result, exp_res);
        chk("d_zero", {31'd0, zero}, {31'd0, exp_res == 32'd0});
        chk("d_illegal", {31'd0, illegal}, {31'd0, exp_ill});
        for (int i = 0; i < hold; i++) begin
            step();
            chk("bp_result", result, exp_res);
            chk("bp_illegal", {31'd0, illegal}, {31'd0, exp_ill});
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("out_valid_after", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_phase = 0; m_rem = 0; m_res = 32'd0; m_ill = 1'b0;
        rst_n = 1'b1; in_valid = 1'b0; aluop = 4'd0; a = 32'd0; b = 32'd0;
        shamt = 5'd0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_result", result, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        do_op(4'd2, 32'h0000_0005, 32'h0000_0007, 5'd9, 32'h0000_000C, 1'b0, 1, 0);
        do_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b0, 1, 0);
        do_op(4'd3, 32'h1234_5678, 32'h8000_0001, 5'd4, 32'h0000_0010, 1'b0, 5, 0);
        do_op(4'd3, 32'h0000_0000, 32'h8000_0001, 5'd0, 32'h8000_0001, 1'b0, 1, 0);
        do_op(4'd3, 32'h0000_0000, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0, 32, 0);
        do_op(4'd2, 32'h1000_0000, 32'h0200_0003, 5'd0, 32'h1200_0003, 1'b0, 1, 10);
        do_op(4'd7, 32'hDEAD_BEEF, 32'h0000_0001, 5'd2, 32'h0000_0000, 1'b1, 1, 3);
        do_op(4'd0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd2, 32'h0000_0000, 1'b0, 1, 0);

        // Reset in the middle of a long shift: operation must be abandoned.
        in_valid = 1'b1; aluop = 4'd3; a = 32'd0; b = 32'h0000_0001; shamt = 5'd31;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        rst_n = 1'b0;
        m_phase = 0;
        #1;
        check_outputs();
        chk("midrst_result", result, 32'd0);
        chk("midrst_zero", {31'd0, zero}, 32'd1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("no_late_result", {31'd0, out_valid}, 32'd0);
        end

        // Randomized traffic, including input churn while busy.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2)      aluop = 4'd0;
            else if (r < 5) aluop = 4'd2;
            else if (r < 8) aluop = 4'd3;
            else            aluop = 4'($urandom_range(0, 15));
            in_valid  = ($urandom_range(0, 2) != 0);
            a         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            b         = ($urandom_range(0, 7) == 0) ? (32'd0 - a) : $urandom;
            shamt     = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 6));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
